// File: rtl/cv32e40p_apu_arbiter_if.sv
// APU bundle between NUM_CORES cv32e40p cores, the shared-FPU arbiter and one FP wrapper.
// Handshakes: a request is held until the cycle its gnt is high, and that cycle is the transfer.
// A response transfers in the single cycle rvalid is high; rvalid cannot be back-pressured.
interface cv32e40p_apu_arbiter_if #(
    parameter int NUM_CORES        = 2,
    parameter int APU_NARGS_CPU    = 3,
    parameter int APU_WOP_CPU      = 6,
    parameter int APU_NDSFLAGS_CPU = 15,
    parameter int APU_NUSFLAGS_CPU = 5
);
    logic [NUM_CORES-1:0]                          core_req_i;
    logic [NUM_CORES-1:0]                          core_gnt_o;
    logic [NUM_CORES-1:0][APU_NARGS_CPU-1:0][31:0] core_operands_i;
    logic [NUM_CORES-1:0][APU_WOP_CPU-1:0]         core_op_i;
    logic [NUM_CORES-1:0][APU_NDSFLAGS_CPU-1:0]    core_flags_i;
    logic [NUM_CORES-1:0]                          core_rvalid_o;
    logic [31:0]                                   core_rdata_o;
    logic [APU_NUSFLAGS_CPU-1:0]                   core_rflags_o;

    logic                                          apu_req_o;
    logic                                          apu_gnt_i;
    logic [APU_NARGS_CPU-1:0][31:0]                apu_operands_o;
    logic [APU_WOP_CPU-1:0]                        apu_op_o;
    logic [APU_NDSFLAGS_CPU-1:0]                   apu_flags_o;
    logic                                          apu_rvalid_i;
    logic [31:0]                                   apu_rdata_i;
    logic [APU_NUSFLAGS_CPU-1:0]                   apu_rflags_i;

    // Arbiter view.
    modport slave (
        input  core_req_i, core_operands_i, core_op_i, core_flags_i,
        input  apu_gnt_i, apu_rvalid_i, apu_rdata_i, apu_rflags_i,
        output core_gnt_o, core_rvalid_o, core_rdata_o, core_rflags_o,
        output apu_req_o, apu_operands_o, apu_op_o, apu_flags_o
    );

    // Environment view: the cores plus the FP wrapper.
    modport master (
        output core_req_i, core_operands_i, core_op_i, core_flags_i,
        output apu_gnt_i, apu_rvalid_i, apu_rdata_i, apu_rflags_i,
        input  core_gnt_o, core_rvalid_o, core_rdata_o, core_rflags_o,
        input  apu_req_o, apu_operands_o, apu_op_o, apu_flags_o
    );
endinterface

// File: rtl/cv32e40p_apu_arbiter.sv
// Round-robin arbiter sharing one FP wrapper among NUM_CORES APU masters.
// Only one transaction is outstanding, so responses always belong to the registered owner.
module cv32e40p_apu_arbiter #(
    parameter int NUM_CORES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    cv32e40p_apu_arbiter_if.slave bus,
    output logic                  busy_o,
    output logic [1:0]            state_o
);
    localparam int ARB_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOCK = 2'd1,
        WAIT = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [ARB_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ARB_W-1:0] owner_q, owner_d;
    logic [ARB_W-1:0] winner, cand, sel;
    logic             any_req;
    logic             free;

    function automatic logic [ARB_W-1:0] ptr_inc(input logic [ARB_W-1:0] p);
        return (p == ARB_W'(NUM_CORES - 1)) ? '0 : p + ARB_W'(1);
    endfunction

    // First requester at or after rr_ptr_q, wrapping modulo NUM_CORES.
    always_comb begin
        any_req = 1'b0;
        winner  = '0;
        cand    = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            cand = ARB_W'((int'(rr_ptr_q) + i) % NUM_CORES);
            if (!any_req && bus.core_req_i[cand]) begin
                any_req = 1'b1;
                winner  = cand;
            end
        end
    end

    always_comb begin
        state_d            = state_q;
        rr_ptr_d           = rr_ptr_q;
        owner_d            = owner_q;
        sel                = owner_q;
        free               = 1'b0;
        bus.core_gnt_o     = '0;
        bus.core_rvalid_o  = '0;
        bus.apu_req_o      = 1'b0;

        case (state_q)
            IDLE: free = 1'b1;
            LOCK: begin
                bus.apu_req_o = 1'b1;
                if (bus.apu_gnt_i) begin
                    bus.core_gnt_o[owner_q] = 1'b1;
                    rr_ptr_d                = ptr_inc(owner_q);
                    state_d                 = WAIT;
                end
            end
            WAIT: begin
                // The response cycle doubles as a free cycle so issue has no bubble.
                if (bus.apu_rvalid_i) begin
                    bus.core_rvalid_o[owner_q] = 1'b1;
                    state_d                    = IDLE;
                    free                       = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (free && any_req) begin
            bus.apu_req_o = 1'b1;
            sel           = winner;
            owner_d       = winner;
            if (bus.apu_gnt_i) begin
                bus.core_gnt_o[winner] = 1'b1;
                rr_ptr_d               = ptr_inc(winner);
                state_d                = WAIT;
            end else begin
                state_d = LOCK;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
        end
    end

    assign bus.apu_operands_o = bus.core_operands_i[sel];
    assign bus.apu_op_o       = bus.core_op_i[sel];
    assign bus.apu_flags_o    = bus.core_flags_i[sel];
    assign bus.core_rdata_o   = bus.apu_rdata_i;
    assign bus.core_rflags_o  = bus.apu_rflags_i;

    assign busy_o  = (state_q != IDLE);
    assign state_o = state_q;

`ifndef SYNTHESIS
    a_gnt_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(bus.core_gnt_o))
        else $error("core_gnt_o has more than one bit set");

    a_rvalid_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(bus.core_rvalid_o))
        else $error("core_rvalid_o has more than one bit set");

    a_lock_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == LOCK && !bus.apu_gnt_i) |=>
        (bus.apu_req_o && $stable(bus.apu_op_o) && $stable(bus.apu_operands_o)
         && $stable(bus.apu_flags_o)))
        else $error("locked APU request changed before grant");

    // A stray response is dropped; this only reports it.
    a_no_spurious_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(bus.apu_rvalid_i && state_q != WAIT))
        else $warning("apu_rvalid_i seen with no outstanding transaction");
`endif
endmodule

// File: tb/tb_cv32e40p_apu_arbiter.sv
// Directed bench for the shared-FPU arbiter with a queue-based grant/response scoreboard.
module tb_cv32e40p_apu_arbiter;
  localparam int NC    = 2;
  localparam int NARGS = 3;
  localparam int WOP   = 6;
  localparam int NDS   = 15;
  localparam int NUS   = 5;
  localparam int GW    = NC + WOP + 32;
  localparam int RW    = NC + 32 + NUS;

  localparam logic [WOP-1:0] OP_ADD = 6'd0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       busy;
  logic [1:0] state;

  cv32e40p_apu_arbiter_if #(
    .NUM_CORES(NC), .APU_NARGS_CPU(NARGS), .APU_WOP_CPU(WOP),
    .APU_NDSFLAGS_CPU(NDS), .APU_NUSFLAGS_CPU(NUS)
  ) bus_if ();

  cv32e40p_apu_arbiter #(.NUM_CORES(NC)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus_if),
    .busy_o (busy),
    .state_o(state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [GW-1:0] exp_gnt_q[$];
  logic [RW-1:0] exp_rv_q[$];
  logic [GW-1:0] mon_ge;
  logic [RW-1:0] mon_re;
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic exp_gnt(input int c, input logic [WOP-1:0] op, input logic [31:0] a);
    exp_gnt_q.push_back({NC'(1 << c), op, a});
  endtask

  task automatic exp_rv(input int c, input logic [31:0] d, input logic [NUS-1:0] f);
    exp_rv_q.push_back({NC'(1 << c), d, f});
  endtask

  // Monitor: every grant or response the DUT presents is matched against the queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_if.core_gnt_o != '0) begin
        if (exp_gnt_q.size() == 0) begin
          check("unexpected_gnt", 64'(bus_if.core_gnt_o), 64'd0);
        end else begin
          mon_ge = exp_gnt_q.pop_front();
          check("gnt", 64'({bus_if.core_gnt_o, bus_if.apu_op_o, bus_if.apu_operands_o[0]}),
                64'(mon_ge));
        end
      end
      if (bus_if.core_rvalid_o != '0) begin
        if (exp_rv_q.size() == 0) begin
          check("unexpected_rvalid", 64'(bus_if.core_rvalid_o), 64'd0);
        end else begin
          mon_re = exp_rv_q.pop_front();
          check("rvalid", 64'({bus_if.core_rvalid_o, bus_if.core_rdata_o, bus_if.core_rflags_o}),
                64'(mon_re));
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic set_core(input int c, input logic req, input logic [WOP-1:0] op,
                          input logic [31:0] a, input logic [31:0] b);
    bus_if.core_req_i[c]         = req;
    bus_if.core_op_i[c]          = op;
    bus_if.core_operands_i[c][0] = a;
    bus_if.core_operands_i[c][1] = b;
    bus_if.core_operands_i[c][2] = 32'(c);
    bus_if.core_flags_i[c]       = NDS'(c + 1);
  endtask

  task automatic wrapper(input logic gnt, input logic rv, input logic [31:0] d,
                         input logic [NUS-1:0] f);
    bus_if.apu_gnt_i    = gnt;
    bus_if.apu_rvalid_i = rv;
    bus_if.apu_rdata_i  = d;
    bus_if.apu_rflags_i = f;
  endtask

  logic [WOP-1:0] cur_op[NC];
  int ord[4] = '{0, 1, 0, 1};
  logic [31:0] d;

  initial begin
    bus_if.core_req_i      = '0;
    bus_if.core_operands_i = '0;
    bus_if.core_op_i       = '0;
    bus_if.core_flags_i    = '0;
    wrapper(1'b0, 1'b0, 32'd0, '0);

    // Reset state
    smp();
    check("rst_gnt", 64'(bus_if.core_gnt_o), 64'd0);
    check("rst_rvalid", 64'(bus_if.core_rvalid_o), 64'd0);
    check("rst_apu_req", 64'(bus_if.apu_req_o), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_state", 64'(state), 64'd0);
    tick();
    rst_n = 1'b1;

    // Single core 0: ADD 1.0 + 2.0, immediate grant, response two cycles later
    tick();
    set_core(0, 1'b1, OP_ADD, 32'h3F80_0000, 32'h4000_0000);
    wrapper(1'b1, 1'b0, 32'd0, '0);
    exp_gnt(0, OP_ADD, 32'h3F80_0000);
    smp();
    check("t1_apu_req", 64'(bus_if.apu_req_o), 64'd1);
    check("t1_operand1", 64'(bus_if.apu_operands_o[1]), 64'h4000_0000);
    check("t1_flags", 64'(bus_if.apu_flags_o), 64'd1);
    check("t1_busy_c0", 64'(busy), 64'd0);
    tick();
    set_core(0, 1'b0, OP_ADD, 32'h3F80_0000, 32'h4000_0000);
    wrapper(1'b0, 1'b0, 32'd0, '0);
    smp();
    check("t1_busy_c1", 64'(busy), 64'd1);
    check("t1_apu_req_wait", 64'(bus_if.apu_req_o), 64'd0);
    tick();
    wrapper(1'b0, 1'b1, 32'h4040_0000, 5'd0);
    exp_rv(0, 32'h4040_0000, 5'd0);
    smp();
    check("t1_rvalid_c2", 64'(bus_if.core_rvalid_o), 64'd1);
    tick();
    wrapper(1'b0, 1'b0, 32'd0, '0);
    smp();
    check("t1_busy_after", 64'(busy), 64'd0);

    // Reset in IDLE to return rr_ptr to 0
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;

    // Both cores request continuously, latency 1: grants 0,1,0,1
    tick();
    cur_op[0] = 6'h10;
    cur_op[1] = 6'h20;
    set_core(0, 1'b1, cur_op[0], 32'hC000_0000 | 32'(cur_op[0]), 32'd0);
    set_core(1, 1'b1, cur_op[1], 32'hC000_0000 | 32'(cur_op[1]), 32'd0);
    wrapper(1'b1, 1'b0, 32'd0, '0);
    exp_gnt(0, cur_op[0], 32'hC000_0000 | 32'(cur_op[0]));
    for (int k = 1; k <= 4; k++) begin
      tick();
      d = 32'h1000_0000 + 32'(k - 1);
      exp_rv(ord[k-1], d, NUS'(k));
      cur_op[ord[k-1]] = cur_op[ord[k-1]] + 6'd1;
      set_core(ord[k-1], 1'b1, cur_op[ord[k-1]], 32'hC000_0000 | 32'(cur_op[ord[k-1]]), 32'd0);
      if (k < 4) begin
        wrapper(1'b1, 1'b1, d, NUS'(k));
        exp_gnt(ord[k], cur_op[ord[k]], 32'hC000_0000 | 32'(cur_op[ord[k]]));
      end else begin
        bus_if.core_req_i = '0;
        wrapper(1'b0, 1'b1, d, NUS'(k));
      end
    end
    tick();
    wrapper(1'b0, 1'b0, 32'd0, '0);
    smp();
    check("t3_busy_after", 64'(busy), 64'd0);

    // LOCK: core 0 held off for 3 cycles, core 1 arrives and must not preempt
    tick();
    set_core(0, 1'b1, 6'h05, 32'h0000_0505, 32'd0);
    smp();
    check("t4_apu_req", 64'(bus_if.apu_req_o), 64'd1);
    check("t4_op_c0", 64'(bus_if.apu_op_o), 64'h05);
    tick();
    set_core(1, 1'b1, 6'h06, 32'h0000_0606, 32'd0);
    smp();
    check("t4_op_c1", 64'(bus_if.apu_op_o), 64'h05);
    check("t4_state_lock", 64'(state), 64'd1);
    check("t4_busy_lock", 64'(busy), 64'd1);
    check("t4_nogrant_c1", 64'(bus_if.core_gnt_o), 64'd0);
    tick();
    smp();
    check("t4_op_c2", 64'(bus_if.apu_op_o), 64'h05);
    tick();
    wrapper(1'b1, 1'b0, 32'd0, '0);
    exp_gnt(0, 6'h05, 32'h0000_0505);
    tick();
    set_core(0, 1'b0, 6'h05, 32'h0000_0505, 32'd0);
    wrapper(1'b0, 1'b0, 32'd0, '0);
    smp();
    check("t4_wait_noreq", 64'(bus_if.apu_req_o), 64'd0);
    // Back-to-back: response for core 0 and grant for core 1 in one cycle
    tick();
    wrapper(1'b1, 1'b1, 32'h0505_0000, 5'd3);
    exp_rv(0, 32'h0505_0000, 5'd3);
    exp_gnt(1, 6'h06, 32'h0000_0606);
    smp();
    check("t4_b2b_rvalid", 64'(bus_if.core_rvalid_o), 64'd1);
    check("t4_b2b_gnt", 64'(bus_if.core_gnt_o), 64'd2);
    tick();
    set_core(1, 1'b0, 6'h06, 32'h0000_0606, 32'd0);
    wrapper(1'b0, 1'b0, 32'd0, '0);
    smp();
    check("t4_busy_wait1", 64'(busy), 64'd1);
    tick();
    wrapper(1'b0, 1'b1, 32'h0606_0000, 5'd4);
    exp_rv(1, 32'h0606_0000, 5'd4);
    tick();
    wrapper(1'b0, 1'b0, 32'd0, '0);
    smp();
    check("t4_busy_after", 64'(busy), 64'd0);

    // Reset while WAIT: response dropped, pointer back to 0
    tick();
    set_core(0, 1'b1, 6'h07, 32'h0000_0707, 32'd0);
    wrapper(1'b1, 1'b0, 32'd0, '0);
    exp_gnt(0, 6'h07, 32'h0000_0707);
    tick();
    set_core(0, 1'b0, 6'h07, 32'h0000_0707, 32'd0);
    wrapper(1'b0, 1'b0, 32'd0, '0);
    smp();
    check("t5_busy_wait", 64'(busy), 64'd1);
    #1;
    rst_n = 1'b0;
    wrapper(1'b0, 1'b1, 32'hDEAD_BEEF, 5'd1);
    #1;
    check("t5_async_busy", 64'(busy), 64'd0);
    check("t5_async_state", 64'(state), 64'd0);
    check("t5_async_rvalid", 64'(bus_if.core_rvalid_o), 64'd0);
    check("t5_async_gnt", 64'(bus_if.core_gnt_o), 64'd0);
    check("t5_async_apu_req", 64'(bus_if.apu_req_o), 64'd0);
    tick();
    smp();
    check("t5_rst_rvalid", 64'(bus_if.core_rvalid_o), 64'd0);
    tick();
    rst_n = 1'b1;
    wrapper(1'b1, 1'b0, 32'd0, '0);
    set_core(1, 1'b1, 6'h08, 32'h0000_0808, 32'd0);
    exp_gnt(1, 6'h08, 32'h0000_0808);
    tick();
    set_core(1, 1'b0, 6'h08, 32'h0000_0808, 32'd0);
    wrapper(1'b0, 1'b0, 32'd0, '0);
    // Both request on the response cycle: rr_ptr must now point at core 0
    tick();
    set_core(0, 1'b1, 6'h09, 32'h0000_0909, 32'd0);
    set_core(1, 1'b1, 6'h0A, 32'h0000_0A0A, 32'd0);
    wrapper(1'b1, 1'b1, 32'h0808_0000, 5'd5);
    exp_rv(1, 32'h0808_0000, 5'd5);
    exp_gnt(0, 6'h09, 32'h0000_0909);
    tick();
    bus_if.core_req_i = '0;
    wrapper(1'b0, 1'b0, 32'd0, '0);
    tick();
    wrapper(1'b0, 1'b1, 32'h0909_0000, 5'd6);
    exp_rv(0, 32'h0909_0000, 5'd6);
    tick();
    wrapper(1'b0, 1'b0, 32'd0, '0);

    // Spurious response while IDLE is ignored
    tick();
    wrapper(1'b0, 1'b1, 32'h0BAD_0BAD, 5'd7);
    smp();
    check("t6_spurious_rvalid", 64'(bus_if.core_rvalid_o), 64'd0);
    check("t6_spurious_busy", 64'(busy), 64'd0);
    tick();
    wrapper(1'b0, 1'b0, 32'd0, '0);

    // Final report
    tick();
    smp();
    check("gnt_queue_drained", 64'(exp_gnt_q.size()), 64'd0);
    check("rv_queue_drained", 64'(exp_rv_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
